tap_config_sequencer: RTL and testbench

//  Sequences the tap selector between a random byte source and the generator core.
//  On request it clears the selector, streams random bytes into it until it reports

---
 rtl/tap_config_sequencer_pkg.sv | 20 ++
 rtl/tap_config_sequencer_if.sv | 31 +++
 rtl/tap_config_sequencer.sv | 139 +++++++++++++
 tb/tb_tap_config_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_config_sequencer_pkg.sv
// Shared definitions for the tap configuration sequencer: state encoding,
// tap field width and a small decode helper.
package tap_config_sequencer_pkg;

    localparam int TAP_W   = 8;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
    localparam logic [STATE_W-1:0] ST_FEED  = 3'd2;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERR   = 3'd5;

    // A configuration is in progress while the selector or generator is being driven.
    function automatic logic is_busy(input logic [STATE_W-1:0] st);
        return (st == ST_CLEAR) || (st == ST_FEED) || (st == ST_LOAD);
    endfunction

endpackage

// File: rtl/tap_config_sequencer_if.sv
// Handshake bundle between the sequencer, the random byte source, the tap
// selector and the generator core. The sequencer side uses the master modport.
interface tap_config_sequencer_if #(
    parameter int NUM_OF_TAPS = 15
);
    import tap_config_sequencer_pkg::*;

    logic [TAP_W-1:0]             rng_data;
    logic                         rng_valid;
    logic                         rng_ready;
    logic                         sel_res;
    logic                         sel_ena;
    logic                         sel_take;
    logic [TAP_W-1:0]             sel_din;
    logic                         sel_done;
    logic [NUM_OF_TAPS*TAP_W-1:0] sel_taps;
    logic [NUM_OF_TAPS*TAP_W-1:0] gen_taps;
    logic                         gen_load;
    logic                         gen_ack;

    modport master (
        input  rng_data, rng_valid, sel_done, sel_taps, gen_ack,
        output rng_ready, sel_res, sel_ena, sel_take, sel_din, gen_taps, gen_load
    );

    modport slave (
        output rng_data, rng_valid, sel_done, sel_taps, gen_ack,
        input  rng_ready, sel_res, sel_ena, sel_take, sel_din, gen_taps, gen_load
    );

endinterface

// File: rtl/tap_config_sequencer.sv
// Tap configuration sequencer: clears the tap selector, streams random bytes
// into it until it reports done, latches the taps and hands them to the
// generator with a load/ack handshake. Bounds the byte count (err on exhaustion).
// Optional feature macro: AUTO_RESEED_EN -- when defined, RUN automatically
// re-enters CLEAR every RESEED_PERIOD cycles.
module tap_config_sequencer
    import tap_config_sequencer_pkg::*;
#(
    parameter int NUM_OF_TAPS   = 15,
    parameter int SIZE          = 32,
    parameter int MAX_FEED      = 1024,
    parameter int RESEED_PERIOD = 65536
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    tap_config_sequencer_if.master bus,
    output logic                  cfg_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int FEED_W = $clog2(MAX_FEED + 1);
    localparam logic [FEED_W-1:0] FEED_LIMIT = FEED_W'(MAX_FEED);

    // Reject configurations the selector/generator pair cannot represent.
    if (SIZE < 2 || NUM_OF_TAPS < 1 || MAX_FEED < 1 || RESEED_PERIOD < 2) begin : g_bad_cfg
        $error("tap_config_sequencer: illegal parameter combination");
    end

    logic [STATE_W-1:0]           state;
    logic [STATE_W-1:0]           state_nxt;
    logic [FEED_W-1:0]            feed_cnt;
    logic                         take_pending;
    logic [TAP_W-1:0]             byte_q;
    logic [NUM_OF_TAPS*TAP_W-1:0] taps_q;
    logic                         accept;
    logic                         reseed_due;

    assign accept = bus.rng_valid && bus.rng_ready;

`ifdef AUTO_RESEED_EN
    localparam int RS_W = $clog2(RESEED_PERIOD);
    localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESEED_PERIOD - 1);

    logic [RS_W-1:0] run_cnt;

    // Count cycles spent in RUN; restart from zero whenever RUN is left or not yet entered.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            run_cnt <= '0;
        end else if (state == ST_RUN && state_nxt == ST_RUN) begin
            run_cnt <= run_cnt + 1'b1;
        end else begin
            run_cnt <= '0;
        end
    end

    assign reseed_due = (state == ST_RUN) && (run_cnt == RS_LAST);
`else
    assign reseed_due = 1'b0;
`endif

    // Next-state decode; a finished selector beats an exhausted byte budget.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_FEED;
            ST_FEED: begin
                if (bus.sel_done) begin
                    state_nxt = ST_LOAD;
                end else if (feed_cnt == FEED_LIMIT) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_LOAD:  if (bus.gen_ack) state_nxt = ST_RUN;
            ST_RUN:   if (start || reseed_due) state_nxt = ST_CLEAR;
            ST_ERR:   if (start) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accepted-byte counter: cleared with the selector, saturating at the budget.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            feed_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            feed_cnt <= '0;
        end else if (accept && feed_cnt != FEED_LIMIT) begin
            feed_cnt <= feed_cnt + 1'b1;
        end
    end

    // One-deep byte stage: an accepted byte is strobed into the selector on the next cycle,
    // and dropped if the selector finishes in the same cycle it was accepted.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            take_pending <= 1'b0;
            byte_q       <= '0;
        end else begin
            take_pending <= accept && (state_nxt == ST_FEED);
            if (accept) begin
                byte_q <= bus.rng_data;
            end
        end
    end

    // Capture the selector's taps on the edge that ends FEED; held until the next capture.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            taps_q <= '0;
        end else if (state == ST_FEED && bus.sel_done) begin
            taps_q <= bus.sel_taps;
        end
    end

    assign bus.sel_res   = (state == ST_CLEAR);
    assign bus.sel_ena   = (state == ST_FEED);
    assign bus.rng_ready = (state == ST_FEED) && !take_pending;
    assign bus.sel_take  = (state == ST_FEED) && take_pending;
    assign bus.sel_din   = byte_q;
    assign bus.gen_taps  = taps_q;
    assign bus.gen_load  = (state == ST_LOAD);

    assign cfg_valid = (state == ST_RUN);
    assign busy      = is_busy(state);
    assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_tap_config_sequencer.sv
// Directed self-checking bench for tap_config_sequencer (MAX_FEED=16,
// RESEED_PERIOD=8). Honours AUTO_RESEED_EN when the build defines it.
module tb_tap_config_sequencer;

    localparam int NT = 15;
    localparam int TW = NT * 8;

    logic clk;
    logic res;
    logic start;
    logic cfg_valid;
    logic busy;
    logic err;

    int vectors;
    int miscompares;

    logic [TW-1:0] taps_a;
    logic [TW-1:0] taps_b;
    logic [TW-1:0] taps_c;

    tap_config_sequencer_if #(.NUM_OF_TAPS(NT)) bus ();

    tap_config_sequencer #(
        .NUM_OF_TAPS  (NT),
        .SIZE         (32),
        .MAX_FEED     (16),
        .RESEED_PERIOD(8)
    ) dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .bus      (bus),
        .cfg_valid(cfg_valid),
        .busy     (busy),
        .err      (err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [TW-1:0] observed,
                               input logic [TW-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one byte, expect it strobed into the selector one cycle later, then idle a cycle.
    task automatic applyStimulus(input logic [7:0] b);
        bus.rng_data  = b;
        bus.rng_valid = 1'b1;
        checkOutput("rng_ready_offer", bus.rng_ready, 1);
        tick();
        checkOutput("sel_take_pulse", bus.sel_take, 1);
        checkOutput("sel_din_byte", bus.sel_din, b);
        checkOutput("rng_ready_inflight", bus.rng_ready, 0);
        bus.rng_valid = 1'b0;
        tick();
        checkOutput("sel_take_single", bus.sel_take, 0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        taps_a       = 120'h1F1E1D1C1B1A19181716151413121_1;
        taps_b       = 120'h0102030405060708090A0B0C0D0E0F;
        taps_c       = 120'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
        res          = 1'b1;
        start        = 1'b0;
        bus.rng_data = 8'h00;
        bus.rng_valid = 1'b0;
        bus.sel_done = 1'b0;
        bus.sel_taps = '0;
        bus.gen_ack  = 1'b0;

        // Reset values.
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cfg_valid", cfg_valid, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_gen_taps", bus.gen_taps, 0);
        checkOutput("rst_gen_load", bus.gen_load, 0);
        checkOutput("rst_rng_ready", bus.rng_ready, 0);
        checkOutput("rst_sel_res", bus.sel_res, 0);
        res = 1'b0;
        tick();

        // Test 1: basic configuration with bytes 3,3,7,0,9.
        start = 1'b1;
        tick();
        checkOutput("t1_clear_sel_res", bus.sel_res, 1);
        checkOutput("t1_clear_sel_ena", bus.sel_ena, 0);
        checkOutput("t1_clear_busy", busy, 1);
        start = 1'b0;
        tick();
        checkOutput("t1_feed_sel_ena", bus.sel_ena, 1);
        checkOutput("t1_feed_sel_res", bus.sel_res, 0);
        applyStimulus(8'd3);
        applyStimulus(8'd3);
        applyStimulus(8'd7);
        applyStimulus(8'd0);
        applyStimulus(8'd9);
        bus.sel_taps = taps_a;
        bus.sel_done = 1'b1;
        tick();
        bus.sel_done = 1'b0;
        checkOutput("t1_load_gen_load", bus.gen_load, 1);
        checkOutput("t1_load_gen_taps", bus.gen_taps, taps_a);
        checkOutput("t1_load_sel_ena", bus.sel_ena, 0);
        checkOutput("t1_load_cfg_valid", cfg_valid, 0);
        bus.gen_ack = 1'b1;
        tick();
        bus.gen_ack = 1'b0;
        checkOutput("t1_run_gen_load", bus.gen_load, 0);
        checkOutput("t1_run_cfg_valid", cfg_valid, 1);
        checkOutput("t1_run_busy", busy, 0);

        // Tests 5 and 3: reconfigure from RUN, old taps stay until LOAD, ack delayed 5 cycles.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t5_clear_cfg_valid", cfg_valid, 0);
        checkOutput("t5_clear_sel_res", bus.sel_res, 1);
        checkOutput("t5_clear_old_taps", bus.gen_taps, taps_a);
        tick();
        bus.sel_taps = taps_b;
        applyStimulus(8'h5A);
        applyStimulus(8'hC3);
        checkOutput("t5_feed_old_taps", bus.gen_taps, taps_a);
        bus.sel_done = 1'b1;
        tick();
        bus.sel_done = 1'b0;
        checkOutput("t5_load_new_taps", bus.gen_taps, taps_b);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_gen_load_held", bus.gen_load, 1);
            checkOutput("t3_cfg_valid_wait", cfg_valid, 0);
            if (i == 4) bus.gen_ack = 1'b1;
            tick();
        end
        bus.gen_ack = 1'b0;
        checkOutput("t3_run_gen_load", bus.gen_load, 0);
        checkOutput("t3_run_cfg_valid", cfg_valid, 1);

        // Test 2: idle source never errs; 16 bytes without completion does.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (40) tick();
        checkOutput("t2_starve_err", err, 0);
        checkOutput("t2_starve_sel_ena", bus.sel_ena, 1);
        for (int i = 0; i < 16; i++) applyStimulus(8'(i + 16));
        checkOutput("t2_err", err, 1);
        checkOutput("t2_err_sel_ena", bus.sel_ena, 0);
        checkOutput("t2_err_busy", busy, 0);
        checkOutput("t2_err_rng_ready", bus.rng_ready, 0);
        tick();
        checkOutput("t2_err_sticky", err, 1);

        // Leave ERR on start; sel_done coinciding with an exhausted budget loads.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t2_restart_err", err, 0);
        checkOutput("t2_restart_sel_res", bus.sel_res, 1);
        tick();
        for (int i = 0; i < 15; i++) applyStimulus(8'(i));
        bus.rng_data  = 8'hEE;
        bus.rng_valid = 1'b1;
        tick();
        bus.rng_valid = 1'b0;
        bus.sel_taps  = taps_c;
        bus.sel_done  = 1'b1;
        tick();
        bus.sel_done  = 1'b0;
        checkOutput("edge_done_wins_load", bus.gen_load, 1);
        checkOutput("edge_done_wins_err", err, 0);
        checkOutput("edge_done_wins_taps", bus.gen_taps, taps_c);
        bus.gen_ack = 1'b1;
        tick();
        bus.gen_ack = 1'b0;
        checkOutput("edge_run_cfg_valid", cfg_valid, 1);

        // Test 4: asynchronous reset mid-FEED with a byte in flight.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        applyStimulus(8'd1);
        applyStimulus(8'd2);
        applyStimulus(8'd3);
        applyStimulus(8'd4);
        bus.rng_data  = 8'hAA;
        bus.rng_valid = 1'b1;
        tick();
        bus.rng_valid = 1'b0;
        checkOutput("t4_inflight_take", bus.sel_take, 1);
        res = 1'b1;
        #1;
        checkOutput("t4_res_sel_take", bus.sel_take, 0);
        checkOutput("t4_res_sel_din", bus.sel_din, 0);
        checkOutput("t4_res_sel_ena", bus.sel_ena, 0);
        checkOutput("t4_res_gen_taps", bus.gen_taps, 0);
        checkOutput("t4_res_busy", busy, 0);
        checkOutput("t4_res_cfg_valid", cfg_valid, 0);
        @(negedge clk);
        res = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t4_reclear_sel_res", bus.sel_res, 1);
        tick();
        checkOutput("t4_refeed_sel_ena", bus.sel_ena, 1);
        applyStimulus(8'h77);
        bus.sel_taps = taps_a;
        bus.sel_done = 1'b1;
        tick();
        bus.sel_done = 1'b0;
        bus.gen_ack  = 1'b1;
        tick();
        bus.gen_ack  = 1'b0;
        checkOutput("t4_run_gen_taps", bus.gen_taps, taps_a);

        // Test 6: RUN dwell without start.
        for (int i = 0; i < 8; i++) begin
            checkOutput("t6_run_dwell", cfg_valid, 1);
            tick();
        end
`ifdef AUTO_RESEED_EN
        checkOutput("t6_reseed_clear", bus.sel_res, 1);
        checkOutput("t6_reseed_cfg_valid", cfg_valid, 0);
`else
        checkOutput("t6_no_reseed_sel_res", bus.sel_res, 0);
        repeat (20) tick();
        checkOutput("t6_no_reseed_cfg_valid", cfg_valid, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
